// File: rtl/cache_fill_ctrl.sv
// Write-strobe generator and multi-word line refill sequencer for the write-through cache.
// Optional build macro CRITICAL_WORD_FIRST_EN: the refill starts at the missed word and wraps around the line.
module cache_fill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int RAM_LAT    = 1,
    parameter int OFS_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic             hit,
    input  logic [OFS_W-1:0] req_ofs,
    output logic             RAM_we,
    output logic             RAM_re,
    output logic             cache_we,
    output logic             cache_src,
    output logic [OFS_W-1:0] fill_ofs,
    output logic             busy,
    output logic             done
);

    localparam int LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [OFS_W-1:0] LAST_WORD = OFS_W'(LINE_WORDS - 1);
    localparam logic [OFS_W-1:0] OFS_ONE   = OFS_W'(1);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(RAM_LAT - 1);
    localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t           state_q;
    logic [OFS_W-1:0] fill_ofs_q;
    logic [OFS_W-1:0] word_cnt_q;
    logic [LAT_W-1:0] lat_cnt_q;
    logic             ram_re_q;
    logic             wr_q;
    logic             busy_q;
    logic             done_q;

    logic [OFS_W-1:0] ofs_inc_d;
    logic [OFS_W-1:0] start_ofs_d;
    logic             miss_d;
    logic             last_word_d;

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_ofs_d = req_ofs;
`else
    logic unused_req_ofs_s;
    assign unused_req_ofs_s = ^req_ofs;
    assign start_ofs_d      = {OFS_W{1'b0}};
`endif

    // Next refill offset (modulo line size) and miss/last-word decode.
    always_comb begin
        ofs_inc_d   = (fill_ofs_q == LAST_WORD) ? {OFS_W{1'b0}} : (fill_ofs_q + OFS_ONE);
        miss_d      = re & ~hit & ~we;
        last_word_d = (word_cnt_q == LAST_WORD);
    end

    // Refill FSM with registered strobes; read misses collided with a write are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fill_ofs_q <= {OFS_W{1'b0}};
            word_cnt_q <= {OFS_W{1'b0}};
            lat_cnt_q  <= {LAT_W{1'b0}};
            ram_re_q   <= 1'b0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_d) begin
                        state_q    <= ISSUE;
                        fill_ofs_q <= start_ofs_d;
                        word_cnt_q <= {OFS_W{1'b0}};
                        ram_re_q   <= 1'b1;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q    <= IDLE;
                    end
                end
                ISSUE: begin
                    ram_re_q <= 1'b0;
                    if (RAM_LAT == 1) begin
                        state_q <= WRITE;
                        wr_q    <= 1'b1;
                        done_q  <= last_word_d;
                    end else begin
                        state_q   <= WAIT;
                        lat_cnt_q <= LAT_ONE;
                    end
                end
                WAIT: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        state_q <= WRITE;
                        wr_q    <= 1'b1;
                        done_q  <= last_word_d;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + LAT_ONE;
                    end
                end
                WRITE: begin
                    wr_q       <= 1'b0;
                    done_q     <= 1'b0;
                    fill_ofs_q <= ofs_inc_d;
                    if (last_word_d) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        word_cnt_q <= {OFS_W{1'b0}};
                    end else begin
                        state_q    <= ISSUE;
                        ram_re_q   <= 1'b1;
                        word_cnt_q <= word_cnt_q + OFS_ONE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    ram_re_q <= 1'b0;
                    wr_q     <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    // Idle write path is combinational; the reset term keeps RAM writes off while in reset.
    assign RAM_we    = we & rst & ~busy_q;
    assign cache_we  = (we & hit & rst & ~busy_q) | wr_q;
    assign cache_src = wr_q;
    assign RAM_re    = ram_re_q;
    assign fill_ofs  = fill_ofs_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: instance A (4 words, latency 1) and instance B (2 words, latency 3).
module tb_cache_fill_ctrl;

    typedef struct {
        int         cyc;
        logic [5:0] vec;     // {RAM_we, RAM_re, cache_we, cache_src, busy, done}
        logic       chk_ofs;
        logic [1:0] ofs;
    } rec_t;

`ifdef CRITICAL_WORD_FIRST_EN
    localparam int CWF = 1;
`else
    localparam int CWF = 0;
`endif
    localparam int NEVER = 32'h3fff_ffff;

    logic       clk = 1'b0;
    logic       rst;
    logic       we_a, re_a, hit_a;
    logic [1:0] ofs_a;
    logic       ram_we_a, ram_re_a, cwe_a, src_a, busy_a, done_a;
    logic [1:0] fofs_a;
    logic       we_b, re_b, hit_b;
    logic [0:0] ofs_b;
    logic       ram_we_b, ram_re_b, cwe_b, src_b, busy_b, done_b;
    logic [0:0] fofs_b;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    rec_t qa[$];
    rec_t qb[$];

    cache_fill_ctrl #(.LINE_WORDS(4), .RAM_LAT(1)) u_a (
        .clk(clk), .rst(rst), .we(we_a), .re(re_a), .hit(hit_a), .req_ofs(ofs_a),
        .RAM_we(ram_we_a), .RAM_re(ram_re_a), .cache_we(cwe_a), .cache_src(src_a),
        .fill_ofs(fofs_a), .busy(busy_a), .done(done_a)
    );

    cache_fill_ctrl #(.LINE_WORDS(2), .RAM_LAT(3)) u_b (
        .clk(clk), .rst(rst), .we(we_b), .re(re_b), .hit(hit_b), .req_ofs(ofs_b),
        .RAM_we(ram_we_b), .RAM_re(ram_re_b), .cache_we(cwe_b), .cache_src(src_b),
        .fill_ofs(fofs_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic rec_t mk(input int c, input logic [5:0] v, input logic chk, input logic [1:0] o);
        rec_t r;
        r.cyc = c; r.vec = v; r.chk_ofs = chk; r.ofs = o;
        return r;
    endfunction

    task automatic push(input bit is_b, input rec_t r);
        if (is_b) qb.push_back(r);
        else      qa.push_back(r);
    endtask

    // Expected refill trace: ISSUE, (lat-1) WAITs, WRITE per word; records after 'cut' are dropped.
    task automatic push_fill(input bit is_b, input int t0, input int lw, input int lat, input int s, input int cut);
        for (int w = 0; w < lw; w++) begin
            int         base;
            logic [1:0] o;
            base = t0 + 1 + w * (lat + 1);
            o    = 2'((s + w) % lw);
            if (base <= cut) push(is_b, mk(base, 6'b010010, 1'b1, o));
            for (int k = 1; k < lat; k++)
                if (base + k <= cut) push(is_b, mk(base + k, 6'b000010, 1'b1, o));
            if (base + lat <= cut)
                push(is_b, mk(base + lat, (w == lw - 1) ? 6'b001111 : 6'b001110, 1'b1, o));
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic mon(input bit is_b, input logic [5:0] got, input logic [1:0] gofs);
        rec_t  r;
        string nm;
        nm = is_b ? "B" : "A";
        while ((is_b ? qb.size() : qa.size()) > 0 && (is_b ? qb[0].cyc : qa[0].cyc) < cyc) begin
            r = is_b ? qb.pop_front() : qa.pop_front();
            checks++; errors++;
            $display("FAIL %s_missing exp_cyc=%0d exp=%b now=%0d", nm, r.cyc, r.vec, cyc);
        end
        if ((is_b ? qb.size() : qa.size()) > 0 && (is_b ? qb[0].cyc : qa[0].cyc) == cyc) begin
            r = is_b ? qb.pop_front() : qa.pop_front();
            checks++;
            if (got !== r.vec || (r.chk_ofs && gofs !== r.ofs)) begin
                errors++;
                $display("FAIL %s_out cyc=%0d got we/re/cwe/src/busy/done=%b ofs=%0d exp=%b ofs=%0d",
                         nm, cyc, got, gofs, r.vec, r.ofs);
            end
        end else if (got != 6'b000000) begin
            checks++; errors++;
            $display("FAIL %s_unexpected cyc=%0d got=%b ofs=%0d", nm, cyc, got, gofs);
        end
    endtask

    // Monitor: compares every cycle in which either DUT shows activity or a record is due.
    always @(negedge clk) begin
        if (mon_en) begin
            mon(1'b0, {ram_we_a, ram_re_a, cwe_a, src_a, busy_a, done_a}, fofs_a);
            mon(1'b1, {ram_we_b, ram_re_b, cwe_b, src_b, busy_b, done_b}, {1'b0, fofs_b});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        we_a = 1'b0; re_a = 1'b0; hit_a = 1'b0; ofs_a = 2'd0;
        we_b = 1'b0; re_b = 1'b0; hit_b = 1'b0; ofs_b = 1'b0;
    endtask

    initial begin
        int t0;
        rst = 1'b1;
        quiet();
        #2;
        rst = 1'b0;
        we_a = 1'b1; re_a = 1'b1; we_b = 1'b1; re_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ram_we_a", int'(ram_we_a), 0);
        chk("rst_cache_we_a", int'(cwe_a), 0);
        chk("rst_busy_a", int'(busy_a), 0);
        chk("rst_fill_ofs_a", int'(fofs_a), 0);
        chk("rst_ram_we_b", int'(ram_we_b), 0);
        chk("rst_cache_we_b", int'(cwe_b), 0);
        chk("rst_busy_b", int'(busy_b), 0);
        chk("rst_fill_ofs_b", int'(fofs_b), 0);

        // Release reset with a write hit on both instances: zero-latency strobes.
        rst = 1'b1;
        re_a = 1'b0; hit_a = 1'b1; re_b = 1'b0; hit_b = 1'b1;
        mon_en = 1'b1;
        push(1'b0, mk(cyc, 6'b101000, 1'b1, 2'd0));
        push(1'b1, mk(cyc, 6'b101000, 1'b1, 2'd0));
        step(); quiet();
        step();

        // Read and write together on a miss: write-around, no refill.
        we_a = 1'b1; re_a = 1'b1; hit_a = 1'b0;
        push(1'b0, mk(cyc, 6'b100000, 1'b0, 2'd0));
        step(); quiet();
        step(); step();

        // A: full refill from offset 0, request held; write pulse in cycle 3 must be ignored.
        re_a = 1'b1; ofs_a = 2'd0;
        t0 = cyc;
        push_fill(1'b0, t0, 4, 1, 0, NEVER);
        for (int c = 1; c <= 8; c++) begin
            step();
            we_a = (cyc == t0 + 3);
            hit_a = (cyc == t0 + 3);
        end
        step();
        we_a = 1'b0; re_a = 1'b1; hit_a = 1'b1;
        step(); quiet();
        step();

        // A: miss on word 2 (critical-word-first order when enabled).
        re_a = 1'b1; ofs_a = 2'd2;
        t0 = cyc;
        push_fill(1'b0, t0, 4, 1, (CWF != 0) ? 2 : 0, NEVER);
        step(); quiet();
        repeat (9) step();

        // B: 2 words at latency 3, write hit pulse in cycle 3 during WAIT.
        re_b = 1'b1; ofs_b = 1'b0;
        t0 = cyc;
        push_fill(1'b1, t0, 2, 3, 0, NEVER);
        for (int c = 1; c <= 8; c++) begin
            step();
            re_b  = 1'b0;
            we_b  = (cyc == t0 + 3);
            hit_b = (cyc == t0 + 3);
        end
        step(); quiet();
        step();

        // B: reset in the WAIT of the second word aborts without done; a new miss restarts cleanly.
        re_b = 1'b1; ofs_b = 1'b1;
        t0 = cyc;
        push_fill(1'b1, t0, 2, 3, (CWF != 0) ? 1 : 0, t0 + 5);
        step(); quiet();
        repeat (5) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        re_b = 1'b1; ofs_b = 1'b1;
        t0 = cyc;
        push_fill(1'b1, t0, 2, 3, (CWF != 0) ? 1 : 0, NEVER);
        step(); quiet();
        repeat (10) step();

        chk("queue_a_drained", qa.size(), 0);
        chk("queue_b_drained", qb.size(), 0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
